// File: rtl/sorting_pkg.sv
// Shared types and constants for the sorting engine.
// Optional build macro: SORTING_DESCEND_EN selects descending order with an all-zeros pad.
package sorting_pkg;

    localparam int unsigned SORTING_N = 8;
    localparam int unsigned SORTING_W = 32;

    typedef enum logic [1:0] {S_IDLE, S_SORT, S_DONE} sort_state_e;

    // Pad bit replicated to element width; chosen so padding always lands at the high indices.
`ifdef SORTING_DESCEND_EN
    localparam logic PAD_BIT = 1'b0;
`else
    localparam logic PAD_BIT = 1'b1;
`endif

endpackage

// File: rtl/sorting_cmp_swap.sv
// Combinational compare-exchange of two unsigned operands.
// Build macro: SORTING_DESCEND_EN flips the swap condition for descending order.
module sorting_cmp_swap
    import sorting_pkg::*;
#(
    parameter int unsigned W = SORTING_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] first_c_o,
    output logic [W-1:0] second_c_o
);

    logic swap_c;

`ifdef SORTING_DESCEND_EN
    assign swap_c = (a_i < b_i);
`else
    assign swap_c = (a_i > b_i);
`endif

    assign first_c_o  = swap_c ? b_i : a_i;
    assign second_c_o = swap_c ? a_i : b_i;

endmodule

// File: rtl/sorting_core.sv
// Odd-even transposition sort engine: load, N-phase sort, indexed readback.
// Build macro: SORTING_DESCEND_EN selects descending order (see sorting_pkg).
module sorting_core
    import sorting_pkg::*;
#(
    parameter int unsigned N = SORTING_N,
    parameter int unsigned W = SORTING_W
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_data,
    input  logic                     start,
    input  logic                     clear,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(N+1)-1:0]   count,
    input  logic [$clog2(N)-1:0]     rd_idx,
    output logic [W-1:0]             rd_data
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned PW = $clog2(N);
    localparam int unsigned NP = N / 2;

    sort_state_e    state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  phase_q, phase_d;
    logic [W-1:0]   data_q [N];
    logic [W-1:0]   data_d [N];
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           in_ready_q, in_ready_d;
    logic [W-1:0]   rd_data_q, rd_data_d;

    logic           accept_c;
    logic [CW-1:0]  fill_c;

    logic [W-1:0]   cmp_a_c      [NP];
    logic [W-1:0]   cmp_b_c      [NP];
    logic [W-1:0]   cmp_first_c  [NP];
    logic [W-1:0]   cmp_second_c [NP];

    // Comparator k sees pair (2k,2k+1) on even phases and (2k+1,2k+2) on odd phases.
    for (genvar k = 0; k < NP; k++) begin : g_cmp
        if (k < NP - 1) begin : g_mux
            assign cmp_a_c[k] = phase_q[0] ? data_q[2*k+1] : data_q[2*k];
            assign cmp_b_c[k] = phase_q[0] ? data_q[2*k+2] : data_q[2*k+1];
        end else begin : g_fixed
            assign cmp_a_c[k] = data_q[2*k];
            assign cmp_b_c[k] = data_q[2*k+1];
        end

        sorting_cmp_swap #(.W(W)) u_cmp (
            .a_i        (cmp_a_c[k]),
            .b_i        (cmp_b_c[k]),
            .first_c_o  (cmp_first_c[k]),
            .second_c_o (cmp_second_c[k])
        );
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        phase_d   = phase_q;
        data_d    = data_q;
        done_d    = 1'b0;
        accept_c  = in_valid && in_ready_q;
        fill_c    = count_q + CW'(accept_c);

        case (state_q)
            S_IDLE: begin
                // A beat accepted alongside start is written before the pad fill.
                for (int i = 0; i < int'(N); i++) begin
                    if (accept_c && (count_q == CW'(i))) begin
                        data_d[i] = in_data;
                    end
                    if (start && (CW'(i) >= fill_c)) begin
                        data_d[i] = {W{PAD_BIT}};
                    end
                end
                count_d = fill_c;
                if (start) begin
                    state_d = S_SORT;
                    phase_d = '0;
                end
            end
            S_SORT: begin
                for (int k = 0; k < int'(NP); k++) begin
                    if (!phase_q[0]) begin
                        data_d[2*k]   = cmp_first_c[k];
                        data_d[2*k+1] = cmp_second_c[k];
                    end else if (k < int'(NP) - 1) begin
                        data_d[2*k+1] = cmp_first_c[k];
                        data_d[2*k+2] = cmp_second_c[k];
                    end
                end
                phase_d = phase_q + PW'(1);
                if (phase_q == PW'(N - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (clear) begin
            state_d = S_IDLE;
            count_d = '0;
            done_d  = 1'b0;
        end

        busy_d     = (state_d == S_SORT);
        in_ready_d = (state_d == S_IDLE) && (count_d < CW'(N));

        // Read from the next-state buffer so the final phase is visible in the done cycle.
        rd_data_d = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (rd_idx == IW'(i)) begin
                rd_data_d = data_d[i];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            phase_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b1;
            rd_data_q  <= '0;
            data_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            phase_q    <= phase_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
            rd_data_q  <= rd_data_d;
            data_q     <= data_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_sorting_core.sv
// Self-checking bench for sorting_core: fixed vectors, corner sequences, random runs vs a queue-sort model.
// Honours SORTING_DESCEND_EN to match the build under test.
module tb_sorting_core;

    localparam int unsigned N  = 8;
    localparam int unsigned W  = 32;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned IW = $clog2(N);

`ifdef SORTING_DESCEND_EN
    localparam logic [W-1:0] PAD = '0;
`else
    localparam logic [W-1:0] PAD = '1;
`endif

    typedef logic [W-1:0] arr_t [N];
    typedef struct {
        int   n;
        arr_t din;
        arr_t expv;
        bit   start_last;
    } vec_t;

    logic           ACLK;
    logic           ARESET;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           start;
    logic           clear;
    logic           busy;
    logic           done;
    logic [CW-1:0]  count;
    logic [IW-1:0]  rd_idx;
    logic [W-1:0]   rd_data;

    int checks = 0;
    int errors = 0;

    sorting_core #(.N(N), .W(W)) dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .start    (start),
        .clear    (clear),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference: pad unloaded slots, then a plain queue sort in the build's direction.
    function automatic arr_t model_sort(input arr_t din, input int n);
        logic [W-1:0] q [$];
        arr_t r;
        for (int i = 0; i < int'(N); i++) q.push_back((i < n) ? din[i] : PAD);
`ifdef SORTING_DESCEND_EN
        q.rsort();
`else
        q.sort();
`endif
        for (int i = 0; i < int'(N); i++) r[i] = q[i];
        return r;
    endfunction

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_count", 64'(count), 64'(0));
        check("clear_ready", 64'(in_ready), 64'(1));
    endtask

    task automatic load(input int n, input arr_t din, input bit start_last);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = din[i];
            check("load_ready", 64'(in_ready), 64'(1));
            if (start_last && (i == n - 1)) start = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!(start_last && (n > 0))) begin
            start = 1'b1;
            tick();
        end
        start = 1'b0;
    endtask

    // Called in the first cycle after the start edge.
    task automatic verify_run(input int n, input arr_t expv);
        for (int k = 1; k <= int'(N); k++) begin
            check("sort_busy", 64'(busy), 64'(1));
            check("sort_nodone", 64'(done), 64'(0));
            if (k == 1) check("sort_ready", 64'(in_ready), 64'(0));
            tick();
        end
        check("done_pulse", 64'(done), 64'(1));
        check("done_busy", 64'(busy), 64'(0));
        check("done_count", 64'(count), 64'(n));
        tick();
        check("done_single", 64'(done), 64'(0));
        for (int i = 0; i < int'(N); i++) begin
            rd_idx = IW'(i);
            tick();
            check("rd_data", 64'(rd_data), 64'(expv[i]));
        end
    endtask

    task automatic sort_and_check(input int n, input arr_t din, input arr_t expv, input bit start_last);
        do_clear();
        load(n, din, start_last);
        verify_run(n, expv);
    endtask

    vec_t vecs [5];
    arr_t din_r;
    arr_t ovr;
    int   acc;
    int   seen;

    initial begin
        ARESET   = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        start    = 1'b0;
        clear    = 1'b0;
        rd_idx   = '0;

        vecs[0].n = 8; vecs[0].start_last = 1'b0;
        vecs[0].din = '{32'd8, 32'd3, 32'd7, 32'd1, 32'd6, 32'd2, 32'd5, 32'd4};
        vecs[1].n = 3; vecs[1].start_last = 1'b0;
        vecs[1].din = '{32'd5, 32'd9, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        vecs[2].n = 3; vecs[2].start_last = 1'b0;
        vecs[2].din = '{32'h10, 32'h02, 32'h07, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        vecs[3].n = 0; vecs[3].start_last = 1'b0;
        vecs[3].din = '{default: 32'd0};
        vecs[4].n = 5; vecs[4].start_last = 1'b1;
        vecs[4].din = '{32'd4, 32'd4, 32'd0, 32'hFFFF_FFFF, 32'd4, 32'd0, 32'd0, 32'd0};
`ifdef SORTING_DESCEND_EN
        vecs[0].expv = '{32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        vecs[1].expv = '{32'd9, 32'd5, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        vecs[2].expv = '{32'h10, 32'h07, 32'h02, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        vecs[3].expv = '{default: 32'd0};
        vecs[4].expv = '{32'hFFFF_FFFF, 32'd4, 32'd4, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0};
`else
        vecs[0].expv = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        vecs[1].expv = '{32'd1, 32'd5, 32'd9, '1, '1, '1, '1, '1};
        vecs[2].expv = '{32'h02, 32'h07, 32'h10, '1, '1, '1, '1, '1};
        vecs[3].expv = '{default: '1};
        vecs[4].expv = '{32'd0, 32'd4, 32'd4, 32'd4, 32'hFFFF_FFFF, '1, '1, '1};
`endif

        tick();
        tick();
        check("rst_count", 64'(count), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_rd_data", 64'(rd_data), 64'(0));
        check("rst_ready", 64'(in_ready), 64'(1));
        ARESET = 1'b0;

        foreach (vecs[v]) sort_and_check(vecs[v].n, vecs[v].din, vecs[v].expv, vecs[v].start_last);

        // start ignored in S_DONE, result held, then clear returns to load.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_start_busy", 64'(busy), 64'(0));
        rd_idx = '0;
        tick();
        check("done_hold", 64'(rd_data), 64'(vecs[4].expv[0]));
        check("done_ready", 64'(in_ready), 64'(0));
        do_clear();

        // Overrun: in_valid held for 10 cycles, only N beats land.
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = W'(100 + i);
            check("ovr_ready", 64'(in_ready), 64'(acc < int'(N)));
            if (acc < int'(N)) begin
                ovr[acc] = W'(100 + i);
                acc++;
            end
            tick();
        end
        in_valid = 1'b0;
        check("ovr_count", 64'(count), 64'(N));
        start = 1'b1;
        tick();
        start = 1'b0;
        verify_run(int'(N), model_sort(ovr, int'(N)));

        // Abort: clear three cycles after start.
        do_clear();
        din_r = '{32'd9, 32'd2, 32'd7, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0};
        load(4, din_r, 1'b0);
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_count", 64'(count), 64'(0));
        check("abort_ready", 64'(in_ready), 64'(1));
        seen = 0;
        for (int k = 0; k < 2 * int'(N); k++) begin
            if (done) seen++;
            tick();
        end
        check("abort_nodone", 64'(seen), 64'(0));

        // start and clear together: clear wins.
        din_r = '{32'd3, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        in_valid = 1'b1; in_data = din_r[0]; tick();
        in_data = din_r[1]; tick();
        in_valid = 1'b0;
        start = 1'b1;
        clear = 1'b1;
        tick();
        start = 1'b0;
        clear = 1'b0;
        check("sc_count", 64'(count), 64'(0));
        check("sc_ready", 64'(in_ready), 64'(1));
        seen = 0;
        for (int k = 0; k < int'(N) + 2; k++) begin
            if (busy || done) seen++;
            tick();
        end
        check("sc_idle", 64'(seen), 64'(0));

        // Reset in the middle of a sort.
        din_r = '{32'd11, 32'd5, 32'd8, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
        load(4, din_r, 1'b0);
        tick();
        tick();
        check("mid_busy", 64'(busy), 64'(1));
        ARESET = 1'b1;
        tick();
        check("rst2_busy", 64'(busy), 64'(0));
        check("rst2_done", 64'(done), 64'(0));
        check("rst2_count", 64'(count), 64'(0));
        check("rst2_ready", 64'(in_ready), 64'(1));
        check("rst2_rd_data", 64'(rd_data), 64'(0));
        ARESET = 1'b0;
        rd_idx = IW'(1);
        tick();
        check("rst2_buf", 64'(rd_data), 64'(0));

        // Random runs against the reference model.
        for (int r = 0; r < 40; r++) begin
            int n;
            bit sl;
            n  = int'($urandom_range(0, N));
            sl = 1'($urandom_range(0, 1));
            for (int i = 0; i < int'(N); i++) begin
                din_r[i] = (r % 2 == 1) ? W'($urandom_range(0, 15)) : W'($urandom);
            end
            sort_and_check(n, din_r, model_sort(din_r, n), sl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sorting_core.md
# sorting_core

Sorting engine that sits directly downstream of the Sorting AXI4-Lite register slave. The register slave pushes operand words into it, issues a start, and reads the ordered results back through an indexed port. It implements an N-phase odd-even transposition sort over an internal register buffer. It raises `done` when the buffer is ordered, and holds the result until cleared.

## Interface
Parameters:
- `N`, 8: number of elements; must be even and ≥ 2.
- `W`, 32: element width in bits, unsigned.

Ports:
- `ACLK`  in  1  clock; all logic on the rising edge.
- `ARESET`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  load beat valid.
- `in_ready`  out  1  load beat accepted when `in_valid & in_ready`.
- `in_data`  in  W  load element.
- `start`  in  1  single-cycle request to begin sorting.
- `clear`  in  1  single-cycle request to return to load state and empty the buffer.
- `busy`  out  1  sort in progress.
- `done`  out  1  one-cycle pulse when the result is ready.
- `count`  out  $clog2(N+1)  number of elements loaded.
- `rd_idx`  in  $clog2(N)  result read index.
- `rd_data`  out  W  registered element at `rd_idx`.

## Operation
- States: S_IDLE (load), S_SORT, S_DONE.
- **S_IDLE**
  - `in_ready = (count < N)`.
  - Each accepted beat writes `buf[count]`, then `count++`.
  - `start` → S_SORT. Slots `count..N-1` are overwritten with the pad value in that same edge. Phase counter is set to 0.
- **S_SORT**
  - One phase per cycle.
  - Even phase compares pairs (0,1),(2,3),…,(N-2,N-1).
  - Odd phase compares pairs (1,2),…,(N-3,N-2).
  - Swap when `buf[i] > buf[i+1]`, unsigned compare, all pairs in parallel.
  - After phase N-1 → S_DONE.
  - `in_ready = 0`; `start` is ignored.
- **S_DONE**
  - `in_ready = 0`; `start` is ignored.
  - Buffer is held until `clear`. `count` keeps the loaded count.
- `clear`, in any state → S_IDLE with `count = 0`. Buffer contents are don't-care. An in-progress sort is aborted; no `done` is produced.
- Simultaneous events:
  - `clear` and `start` in the same cycle: `clear` wins.
  - `in_valid` and `start` in the same S_IDLE cycle: the beat is accepted and included in the sort.
- `start` with `count == 0` still runs a full sort over pad values and still produces `done`.
- Reset values:
  - state S_IDLE.
  - `count`, `busy`, `done`, `rd_data` = 0.
  - buffer all 0.
  - `in_ready` = 1.

## Timing
- `start` high in cycle c:
  - `busy` is high in cycles c+1..c+N.
  - `done` is high in cycle c+N+1 only; `busy` is low in that cycle.
  - Total latency from `start` to `done` is N+1 cycles, independent of the data.
- `rd_data` registers `buf[rd_idx]` with one-cycle latency, in every state.
- `rd_data` is guaranteed ordered only from the `done` cycle onward.
- `rd_idx ≥ N` → `rd_data = 0`.
- Load throughput is one beat per cycle. `in_ready` drops in the cycle after the N-th accept.

## Configuration
- `SORTING_DESCEND_EN` defined:
  - Swap condition becomes `buf[i] < buf[i+1]`, giving descending order.
  - Pad value is all-zeros, so padded slots settle at the high indices.
- `SORTING_DESCEND_EN` undefined:
  - Ascending order.
  - Pad value is all-ones, so padded slots settle at the high indices.
- Latency and interface are identical in both builds.

## Structure
- Package `sorting_pkg` holds:
  - `typedef enum logic [1:0] {S_IDLE, S_SORT, S_DONE} sort_state_e`.
  - Default `N`/`W` localparams.
  - Pad constant, selected by `SORTING_DESCEND_EN`.
- Sub-module `sorting_cmp_swap`:
  - Combinational compare-exchange of two W-bit operands, honouring the macro.
  - Instantiated N/2 times. The odd phase uses the first N/2-1 instances, re-muxed by phase parity.
- The top level holds the FSM, phase counter, buffer, load pointer and read register.

## Test plan
1. **Full load, ascending build.** Load 8,3,7,1,6,2,5,4, then `start`. Expect `done` exactly 9 cycles later. Reading idx 0..7 gives 1,2,3,4,5,6,7,8.
2. **Descending build.** Same data gives 8,7,6,5,4,3,2,1. Load 3 values, 5,9,1, and sort: result is 9,5,1,0,0,0,0,0.
3. **Partial load, ascending.** Load 0x10,0x02,0x07 and sort. idx 0..2 read 0x02,0x07,0x10; idx 3..7 read 0xFFFFFFFF; `count` = 3.
4. **Back-pressure and overrun.** Hold `in_valid` for 10 cycles. Exactly 8 beats are accepted; `in_ready` = 0 from the 9th cycle; `count` = 8.
5. **Abort.** Pulse `clear` 3 cycles after `start`. `busy` drops next cycle, no `done` pulse ever, `count` = 0, `in_ready` = 1.
6. **Simultaneous events and reset.**
   - `start`+`clear` together: stays in S_IDLE with no `busy`.
   - `ARESET` mid-sort: all outputs return to reset values on the next edge.
